fifo_wr_arb: RTL and testbench
==============================

Name: fifo_wr_arb

Overview:
- Write-side arbiter and sequencer for the async FIFO write port (en_w/data_w/full).
- Shares the single FIFO write port between NUM_REQ requesters using round-robin bursts.
- Sits entirely in the write clock domain, between producer blocks and the FIFO.
- The read side is untouched by this block.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DW, 8, data width; matches FIFO data_w width.
- BURST_MAX, 4, maximum beats per grant (1..16).

Ports:
- clk_w  input  1  write-domain clock; all logic on its rising edge.
- rst_w  input  1  asynchronous reset, active-high.
- req_valid  input  NUM_REQ  per-requester beat valid.
- req_data  input  NUM_REQ*DW  per-requester data; requester i occupies bits [i*DW +: DW].
- req_ready  output  NUM_REQ  per-requester beat accepted this cycle.
- full  input  1  FIFO full flag, already synchronous to clk_w.
- en_w  output  1  FIFO write enable.
- data_w  output  DW  FIFO write data.
- gnt  output  NUM_REQ  one-hot current grant; all zero when IDLE.
- busy  output  1  high in GRANT state.
- stall_cnt  output  16  full-stall statistics (see Optional Feature).

Behaviour:
- Clock and reset: one clock, clk_w; reset rst_w is asynchronous and active-high.
- Reset state:
  - state=IDLE, rr_ptr=0, beat_cnt=0, gnt=0, busy=0, stall_cnt=0.
  - Therefore en_w=0, req_ready=0 and data_w=0.
- State machine: IDLE, GRANT.
- IDLE:
  - If any req_valid is high, select the first valid requester searching from rr_ptr upward, wrapping from NUM_REQ-1 to 0.
  - Register the winner into gnt, clear beat_cnt, go to GRANT.
  - If no req_valid is high, stay in IDLE.
  - No beat is transferred in IDLE, so there is a 1-cycle arbitration bubble.
- GRANT, combinational outputs for the granted requester g:
  - req_ready[g] = ~full.
  - en_w = req_valid[g] & ~full.
  - data_w = req_data[g] when en_w is high, else 0.
  - Every req_ready bit other than g is 0.
- Beat rule: a beat transfers when req_valid[g] & req_ready[g]. Zero latency: the FIFO write happens in the same cycle as acceptance.
- Beat count: beat_cnt increments on each beat.
- Leaving GRANT:
  - After a beat with beat_cnt==BURST_MAX-1, go to IDLE.
  - If req_valid[g] is low, go to IDLE immediately; voluntary release, no beat.
- On any exit from GRANT: rr_ptr = (g+1) mod NUM_REQ, gnt cleared.
- full high in GRANT:
  - Grant is held, no beat transfers, beat_cnt frozen, no timeout.
  - Requester must hold req_valid and req_data stable while not ready.
- full and valid change in the same cycle: outputs follow current inputs combinationally; no registered lookahead.
- Requester drops valid mid-burst: grant released, and the remaining burst allowance is forfeited.
- BURST_MAX=1: every grant transfers exactly one beat, then returns to IDLE.
- Reset asserted mid-burst:
  - All state returns to reset values immediately and asynchronously.
  - en_w deasserts with no clock edge.
  - A partially sent burst is not resumed.
- Fairness: a continuously requesting requester is served at most one grant out of every NUM_REQ grants while others request.

Optional Feature:
- Macro: FIFO_WR_ARB_STATS_EN.
- Defined:
  - stall_cnt increments each cycle in GRANT with req_valid[g] & full.
  - 16-bit, saturates at 16'hFFFF.
  - Cleared only by rst_w.
- Undefined: no counter logic; stall_cnt is tied to 0. The port is always present.

Test Plan:
- Single requester, reset then req_valid[0]=1 with data 8'h10..8'h17, full=0, BURST_MAX=4 -> 1 bubble, then 4 writes 10..13 on en_w, 1 IDLE cycle, then 4 writes 14..17; gnt=4'b0001 during bursts.
- All four requesters valid continuously -> grant order 0,1,2,3,0; each grant carries exactly 4 beats; requester i's data only appears while gnt[i]=1.
- Requester 2 granted, full=1 for 5 cycles mid-burst -> en_w=0, req_ready=0, beat_cnt frozen, gnt held; burst completes after full drops; with FIFO_WR_ARB_STATS_EN, stall_cnt=5.
- Requester 1 drops valid after 2 beats -> GRANT exits next edge, rr_ptr=2; requester 3 valid next -> granted ahead of requester 0.
- rst_w pulsed asynchronously mid-burst -> en_w, gnt and busy drop at once; after release, arbitration restarts from requester 0.
- FIFO_WR_ARB_STATS_EN defined, full held high 70000 cycles while granted -> stall_cnt saturates at 16'hFFFF; macro undefined -> stall_cnt stays 0.

Source files
------------

// File: rtl/fifo_wr_arb.sv
// Round-robin burst arbiter sharing one FIFO write port between NUM_REQ producers.
// Optional full-stall counter enabled by defining FIFO_WR_ARB_STATS_EN.
module fifo_wr_arb #(
    parameter int NUM_REQ   = 4,
    parameter int DW        = 8,
    parameter int BURST_MAX = 4
) (
    input  logic                  clk_w,
    input  logic                  rst_w,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*DW-1:0] req_data,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic                  full,
    output logic                  en_w,
    output logic [DW-1:0]         data_w,
    output logic [NUM_REQ-1:0]    gnt,
    output logic                  busy,
    output logic [15:0]           stall_cnt
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int BW = $clog2(BURST_MAX + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [BW-1:0]        beat_cnt_q, beat_cnt_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic                 busy_q, busy_d;

    logic [IW-1:0]        pick_idx;
    logic [IW-1:0]        cand;
    logic                 valid_g;
    logic                 beat;
    logic                 last_beat;

    assign valid_g   = req_valid[idx_q];
    assign beat      = (state_q == GRANT) && valid_g && !full;
    assign last_beat = (beat_cnt_q == BW'(BURST_MAX - 1));

    // Scan downward so the candidate closest to rr_ptr is the one left standing.
    always_comb begin
        pick_idx = rr_ptr_q;
        cand     = rr_ptr_q;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = IW'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (req_valid[cand]) pick_idx = cand;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        gnt_d      = gnt_q;
        busy_d     = busy_q;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    state_d    = GRANT;
                    idx_d      = pick_idx;
                    gnt_d      = NUM_REQ'(1) << pick_idx;
                    busy_d     = 1'b1;
                    beat_cnt_d = '0;
                end
            end
            GRANT: begin
                if (!valid_g || (beat && last_beat)) begin
                    state_d    = IDLE;
                    gnt_d      = '0;
                    busy_d     = 1'b0;
                    beat_cnt_d = '0;
                    rr_ptr_d   = IW'((int'(idx_q) + 1) % NUM_REQ);
                end else if (beat) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_w or posedge rst_w) begin
        if (rst_w) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            gnt_q      <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            gnt_q      <= gnt_d;
            busy_q     <= busy_d;
        end
    end

    // Write path is combinational so a beat lands in the FIFO the cycle it is accepted.
    assign req_ready = ((state_q == GRANT) && !full) ? gnt_q : '0;
    assign en_w      = beat;
    assign data_w    = beat ? req_data[idx_q*DW +: DW] : '0;
    assign gnt       = gnt_q;
    assign busy      = busy_q;

`ifdef FIFO_WR_ARB_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == GRANT) && valid_g && full && (stall_cnt_q != 16'hFFFF))
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk_w or posedge rst_w) begin
        if (rst_w) stall_cnt_q <= '0;
        else       stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: directed scenarios plus random traffic against a
// cycle-level behavioural model of the arbitration rules.
module tb_fifo_wr_arb;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int BM = 4;

    logic              clk_w;
    logic              rst_w;
    logic [N-1:0]      req_valid;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic              full;
    logic              en_w;
    logic [DW-1:0]     data_w;
    logic [N-1:0]      gnt;
    logic              busy;
    logic [15:0]       stall_cnt;

    fifo_wr_arb #(.NUM_REQ(N), .DW(DW), .BURST_MAX(BM)) dut (
        .clk_w     (clk_w),
        .rst_w     (rst_w),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .full      (full),
        .en_w      (en_w),
        .data_w    (data_w),
        .gnt       (gnt),
        .busy      (busy),
        .stall_cnt (stall_cnt)
    );

    initial begin
        clk_w = 1'b0;
        forever #5 clk_w = ~clk_w;
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: who owns the port, how many beats used, where the search starts.
    int m_busy, m_g, m_beats, m_ptr, m_stall, m_acc;

    always @(posedge clk_w or posedge rst_w) begin
        if (rst_w) begin
            m_busy = 0; m_g = 0; m_beats = 0; m_ptr = 0; m_stall = 0; m_acc = -1;
        end else begin
            m_acc = -1;
            if (m_busy != 0) begin
                if (!req_valid[m_g]) begin
                    m_busy = 0;
                    m_ptr  = (m_g + 1) % N;
                end else if (!full) begin
                    m_acc = m_g;
                    m_beats++;
                    if (m_beats == BM) begin
                        m_busy = 0;
                        m_ptr  = (m_g + 1) % N;
                    end
                end else begin
`ifdef FIFO_WR_ARB_STATS_EN
                    if (m_stall < 65535) m_stall++;
`endif
                end
            end else if (req_valid != '0) begin
                for (int k = 0; k < N; k++) begin
                    if (req_valid[(m_ptr + k) % N]) begin
                        m_g = (m_ptr + k) % N;
                        break;
                    end
                end
                m_busy  = 1;
                m_beats = 0;
            end
        end
    end

    // Compare against the model every cycle, and log writes and grant starts.
    logic [DW-1:0] wr_q[$];
    logic [N-1:0]  gq[$];
    logic          prev_busy;

    always @(negedge clk_w) begin
        if (rst_w) begin
            prev_busy = 1'b0;
        end else begin
            logic          e_en;
            logic [N-1:0]  e_gnt;
            e_en  = (m_busy != 0) && req_valid[m_g] && !full;
            e_gnt = (m_busy != 0) ? N'(1) << m_g : '0;
            chk("cyc_busy",  32'(busy), 32'(m_busy != 0));
            chk("cyc_gnt",   32'(gnt), 32'(e_gnt));
            chk("cyc_ready", 32'(req_ready), full ? 32'd0 : 32'(e_gnt));
            chk("cyc_en_w",  32'(en_w), 32'(e_en));
            chk("cyc_data_w", 32'(data_w), e_en ? 32'(req_data[m_g*DW +: DW]) : 32'd0);
            chk("cyc_stall", 32'(stall_cnt), 32'(m_stall));
            if (en_w) wr_q.push_back(data_w);
            if (busy && !prev_busy) gq.push_back(gnt);
            prev_busy = busy;
        end
    end

    // Each requester streams base+n, advancing only when the model says a beat was taken.
    logic [DW-1:0] base[N];
    int            cnt[N];

    task automatic drive_data();
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = DW'(int'(base[i]) + cnt[i]);
    endtask

    task automatic step();
        @(posedge clk_w);
        #1;
        if (m_acc >= 0) cnt[m_acc]++;
        drive_data();
    endtask

    task automatic apply_reset();
        rst_w     = 1'b1;
        req_valid = '0;
        full      = 1'b0;
        for (int i = 0; i < N; i++) cnt[i] = 0;
        drive_data();
        #1;
        chk("rst_en_w",  32'(en_w), 32'd0);
        chk("rst_gnt",   32'(gnt), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_data",  32'(data_w), 32'd0);
        chk("rst_stall", 32'(stall_cnt), 32'd0);
        repeat (2) @(posedge clk_w);
        #1;
        rst_w = 1'b0;
        wr_q.delete();
        gq.delete();
    endtask

    initial begin
        rst_w = 1'b1;
        req_valid = '0;
        full = 1'b0;
        req_data = '0;
        for (int i = 0; i < N; i++) begin
            base[i] = DW'(i * 8'h40);
            cnt[i]  = 0;
        end

        // Single requester: bubble, 4 beats, bubble, 4 beats.
        base[0] = 8'h10;
        apply_reset();
        req_valid = 4'b0001;
        step();
        chk("t1_bubble", wr_q.size(), 0);
        repeat (8) step();
        chk("t1_wr_after9", wr_q.size(), 7);
        step();
        chk("t1_wr_after10", wr_q.size(), 8);
        for (int j = 0; j < 8 && j < wr_q.size(); j++) chk("t1_data", 32'(wr_q[j]), 32'h10 + j);
        chk("t1_grants", gq.size(), 2);
        if (gq.size() >= 2) begin
            chk("t1_gnt0", 32'(gq[0]), 32'b0001);
            chk("t1_gnt1", 32'(gq[1]), 32'b0001);
        end
        req_valid = '0;
        base[0] = 8'h00;

        // All requesters busy: order 0,1,2,3,0, four beats each.
        apply_reset();
        req_valid = 4'b1111;
        repeat (25) step();
        chk("t2_grants", gq.size(), 5);
        for (int j = 0; j < 5 && j < gq.size(); j++) chk("t2_order", 32'(gq[j]), 32'(1 << (j % 4)));
        chk("t2_writes", wr_q.size(), 20);
        for (int j = 0; j < 20 && j < wr_q.size(); j++)
            chk("t2_data", 32'(wr_q[j]), 32'(((j / 4) % 4) * 8'h40 + (j % 4) + (j / 16) * 4));
        req_valid = '0;

        // Requester 2 stalled by full for 5 cycles mid-burst.
        apply_reset();
        req_valid = 4'b0100;
        repeat (3) step();
        full = 1'b1;
        #1;
        for (int j = 0; j < 5; j++) begin
            if (j > 0) step();
            chk("t3_en_stall", 32'(en_w), 32'd0);
            chk("t3_ready_stall", 32'(req_ready), 32'd0);
            chk("t3_gnt_held", 32'(gnt), 32'b0100);
        end
        step();
        full = 1'b0;
        repeat (2) step();
        chk("t3_writes", wr_q.size(), 4);
        for (int j = 0; j < 4 && j < wr_q.size(); j++) chk("t3_data", 32'(wr_q[j]), 32'h80 + j);
        chk("t3_busy_end", 32'(busy), 32'd0);
`ifdef FIFO_WR_ARB_STATS_EN
        chk("t3_stall", 32'(stall_cnt), 32'd5);
`else
        chk("t3_stall", 32'(stall_cnt), 32'd0);
`endif
        req_valid = '0;

        // Voluntary release after 2 beats moves the pointer past requester 1.
        apply_reset();
        req_valid = 4'b0010;
        repeat (3) step();
        req_valid = 4'b0000;
        #1;
        chk("t4_busy_drop_cyc", 32'(busy), 32'd1);
        chk("t4_en_drop_cyc", 32'(en_w), 32'd0);
        step();
        chk("t4_idle", 32'(busy), 32'd0);
        chk("t4_model_ptr", m_ptr, 2);
        chk("t4_writes", wr_q.size(), 2);
        req_valid = 4'b1001;
        step();
        chk("t4_gnt3", 32'(gnt), 32'b1000);
        req_valid = '0;

        // Async reset in the middle of requester 1's burst.
        apply_reset();
        req_valid = 4'b1111;
        repeat (6) step();
        #1;
        chk("t5_gnt_pre", 32'(gnt), 32'b0010);
        chk("t5_en_pre", 32'(en_w), 32'd1);
        #2;
        rst_w = 1'b1;
        #1;
        chk("t5_en_async", 32'(en_w), 32'd0);
        chk("t5_gnt_async", 32'(gnt), 32'd0);
        chk("t5_busy_async", 32'(busy), 32'd0);
        #2;
        rst_w = 1'b0;
        step();
        chk("t5_restart", 32'(gnt), 32'b0001);
        req_valid = '0;

        // Random traffic checked cycle by cycle against the model.
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) req_valid[i] = ($urandom_range(0, 9) < 6);
            full = ($urandom_range(0, 3) == 0);
            step();
        end
        req_valid = '0;
        full = 1'b0;

        // Long full stall on a held grant.
        apply_reset();
        req_valid = 4'b0001;
        full = 1'b1;
`ifdef FIFO_WR_ARB_STATS_EN
        repeat (70000) step();
        chk("t6_stall_sat", 32'(stall_cnt), 32'hFFFF);
`else
        repeat (300) step();
        chk("t6_stall_zero", 32'(stall_cnt), 32'd0);
`endif
        chk("t6_gnt_held", 32'(gnt), 32'b0001);
        req_valid = '0;
        full = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
